// File: rtl/horizontal_tf_pkg.sv
// Shared types, default sizes and helpers for the horizontal twiddle-factor generator.
package horizontal_tf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_WAIT = 2'd2,
    ST_FIN  = 2'd3
  } tf_state_t;

  localparam int DEF_P_WIDTH   = 64;
  localparam int DEF_CH        = 15;
  localparam int DEF_CNT_WIDTH = 10;
  localparam int DEF_MUL_LAT   = 3;

  // Width of a packed bus carrying ch channels of w bits each.
  function automatic int slice_w(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/horizontal_modmul_pipe.sv
// Modular multiplier: full 2*P_WIDTH-bit product reduced mod N, delivered MUL_LAT cycles after issue.
module horizontal_modmul_pipe
  import horizontal_tf_pkg::*;
#(
  parameter int P_WIDTH = DEF_P_WIDTH,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [P_WIDTH-1:0] a,
  input  logic [P_WIDTH-1:0] b,
  input  logic [P_WIDTH-1:0] N,
  output logic [P_WIDTH-1:0] result,
  output logic               out_valid
);

  logic [2*P_WIDTH-1:0] prod;
  logic [P_WIDTH-1:0]   prod_mod;
  logic [P_WIDTH-1:0]   stage_data [MUL_LAT];
  logic [MUL_LAT-1:0]   stage_valid;

  always_comb begin
    prod     = {{P_WIDTH{1'b0}}, a} * {{P_WIDTH{1'b0}}, b};
    prod_mod = P_WIDTH'(prod % {{P_WIDTH{1'b0}}, N});
  end

  // Reduction lands in stage 0; the remaining stages only delay it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        stage_data[i] <= '0;
      end
    end else begin
      stage_valid[0] <= in_valid;
      stage_data[0]  <= prod_mod;
      for (int i = 1; i < MUL_LAT; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_data[i]  <= stage_data[i-1];
      end
    end
  end

  assign result    = stage_data[MUL_LAT-1];
  assign out_valid = stage_valid[MUL_LAT-1];

endmodule

// File: rtl/horizontal_tf_gen.sv
// Horizontal twiddle generator: emits base_j * step_j^k mod N for k = 0..len_m1 on CH channels.
// Optional tf_idx output is enabled by defining HORIZONTAL_TF_GEN_INDEX_EN.
module horizontal_tf_gen
  import horizontal_tf_pkg::*;
#(
  parameter int P_WIDTH   = DEF_P_WIDTH,
  parameter int CH        = DEF_CH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int MUL_LAT   = DEF_MUL_LAT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [CNT_WIDTH-1:0]             len_m1,
  input  logic [slice_w(CH, P_WIDTH)-1:0]  base_in,
  input  logic [slice_w(CH, P_WIDTH)-1:0]  step_in,
  input  logic [P_WIDTH-1:0]               N_in,
  input  logic                             stall,
  output logic [slice_w(CH, P_WIDTH)-1:0]  tf_out,
  output logic                             tf_valid,
  output logic                             busy,
  output logic                             done
`ifdef HORIZONTAL_TF_GEN_INDEX_EN
  ,
  output logic [CNT_WIDTH-1:0]             tf_idx
`endif
);

  localparam int VW = slice_w(CH, P_WIDTH);

  tf_state_t            state;
  logic [CNT_WIDTH-1:0] k;
  logic [CNT_WIDTH-1:0] len;
  logic [VW-1:0]        step;
  logic [VW-1:0]        cur;
  logic [VW-1:0]        last_out;
  logic [P_WIDTH-1:0]   n_mod;
  logic [VW-1:0]        mul_res;
  logic [CH-1:0]        mul_valid;
  logic                 emit_fire;
  logic                 mul_done;

  for (genvar j = 0; j < CH; j++) begin : g_ch
    horizontal_modmul_pipe #(
      .P_WIDTH (P_WIDTH),
      .MUL_LAT (MUL_LAT)
    ) u_mul (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (emit_fire),
      .a         (cur[j*P_WIDTH +: P_WIDTH]),
      .b         (step[j*P_WIDTH +: P_WIDTH]),
      .N         (n_mod),
      .result    (mul_res[j*P_WIDTH +: P_WIDTH]),
      .out_valid (mul_valid[j])
    );
  end

  // Channels run in lockstep, so every multiplier is valid in the same cycle.
  always_comb begin
    emit_fire = (state == ST_EMIT) && !stall;
    mul_done  = &mul_valid;
    tf_valid  = emit_fire;
    busy      = (state != ST_IDLE);
    done      = (state == ST_FIN);
    if (emit_fire) begin
      tf_out = cur;
    end else begin
      tf_out = last_out;
    end
  end

  // Sequencer: latch job parameters, emit, wait for the multipliers, advance k.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      k        <= '0;
      len      <= '0;
      step     <= '0;
      n_mod    <= '0;
      cur      <= '0;
      last_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            len   <= len_m1;
            step  <= step_in;
            n_mod <= N_in;
            cur   <= base_in;
            k     <= '0;
            state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (!stall) begin
            last_out <= cur;
            if (k == len) begin
              state <= ST_FIN;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mul_done) begin
            cur   <= mul_res;
            k     <= k + CNT_WIDTH'(1);
            state <= ST_EMIT;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef HORIZONTAL_TF_GEN_INDEX_EN
  assign tf_idx = k;
`endif

endmodule

// File: tb/tb_horizontal_tf_gen.sv
// Scoreboard bench for horizontal_tf_gen: directed sequences plus randomized jobs with random stall.
module tb_horizontal_tf_gen;

  localparam int PW  = 64;
  localparam int NCH = 3;
  localparam int CW  = 10;
  localparam int LAT = 3;
  localparam int VW  = PW * NCH;

  typedef logic [VW-1:0] vec_t;
  typedef struct {
    vec_t v;
    int   idx;
    bit   last;
    int   ecyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stall;
  logic [CW-1:0] len_m1;
  vec_t          base_in;
  vec_t          step_in;
  logic [PW-1:0] N_in;
  vec_t          tf_out;
  logic          tf_valid;
  logic          busy;
  logic          done;
`ifdef HORIZONTAL_TF_GEN_INDEX_EN
  logic [CW-1:0] tf_idx;
`endif

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   mon_en   = 1'b0;
  bit   done_due = 1'b0;
  vec_t last_exp = '0;

  horizontal_tf_gen #(
    .P_WIDTH   (PW),
    .CH        (NCH),
    .CNT_WIDTH (CW),
    .MUL_LAT   (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len_m1   (len_m1),
    .base_in  (base_in),
    .step_in  (step_in),
    .N_in     (N_in),
    .stall    (stall),
    .tf_out   (tf_out),
    .tf_valid (tf_valid),
    .busy     (busy),
    .done     (done)
`ifdef HORIZONTAL_TF_GEN_INDEX_EN
    ,
    .tf_idx   (tf_idx)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [PW-1:0] mulmod(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                           input logic [PW-1:0] n);
    logic [2*PW-1:0] p;
    p = {64'd0, a} * {64'd0, b};
    return PW'(p % {64'd0, n});
  endfunction

  function automatic logic [PW-1:0] powmod(input logic [PW-1:0] s, input int e, input logic [PW-1:0] n);
    logic [PW-1:0] p;
    p = 64'd1;
    for (int i = 0; i < e; i++) p = mulmod(p, s, n);
    return p;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int j = 0; j < VW / 32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic vec_t mk3(input logic [PW-1:0] c0, input logic [PW-1:0] c1, input logic [PW-1:0] c2);
    return {c2, c1, c0};
  endfunction

  // Monitor: pops an expectation for every tf_valid and checks hold/done/stall behaviour.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (done || done_due) chk("done", {191'd0, done}, {191'd0, done_due});
      done_due = 1'b0;
      if (stall) chk("valid_in_stall", {191'd0, tf_valid}, '0);
      if (tf_valid) begin
        chk("busy_with_valid", {191'd0, busy}, {191'd0, 1'b1});
        if (sbq.size() == 0) begin
          chk("unexpected_valid", {191'd0, tf_valid}, '0);
        end else begin
          e = sbq.pop_front();
          chk("tf_out", tf_out, e.v);
`ifdef HORIZONTAL_TF_GEN_INDEX_EN
          chk("tf_idx", VW'(tf_idx), VW'(e.idx));
`endif
          if (e.ecyc >= 0) chk("timing", VW'(cyc), VW'(e.ecyc));
          last_exp = e.v;
          done_due = e.last;
        end
      end else begin
        chk("hold", tf_out, last_exp);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    mon_en = 1'b0;
    sbq.delete();
    done_due = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    last_exp = '0;
    chk("rst_valid", {191'd0, tf_valid}, '0);
    chk("rst_busy", {191'd0, busy}, '0);
    chk("rst_done", {191'd0, done}, '0);
    chk("rst_out", tf_out, '0);
    mon_en = 1'b1;
  endtask

  task automatic start_seq(input vec_t b, input vec_t s, input logic [PW-1:0] n, input int len,
                           input bit timed);
    int c0;
    c0 = cyc;
    for (int k = 0; k <= len; k++) begin
      exp_t e;
      for (int j = 0; j < NCH; j++) begin
        if (k == 0) e.v[j*PW +: PW] = b[j*PW +: PW];
        else        e.v[j*PW +: PW] = mulmod(b[j*PW +: PW], powmod(s[j*PW +: PW], k, n), n);
      end
      e.idx  = k;
      e.last = (k == len);
      e.ecyc = timed ? c0 + 1 + k * (LAT + 1) : -1;
      sbq.push_back(e);
    end
    base_in = b;
    step_in = s;
    N_in    = n;
    len_m1  = CW'(len);
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    base_in = rand_vec();
    step_in = rand_vec();
    N_in    = {$urandom, $urandom};
    len_m1  = CW'($urandom);
  endtask

  task automatic wait_cyc(input int t);
    for (int i = 0; i < 1000 && cyc < t; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input bit rand_stall);
    for (int i = 0; i < 3000 && sbq.size() != 0; i++) begin
      @(posedge clk); #1;
      if (rand_stall) stall = ($urandom_range(0, 3) == 0);
    end
    stall = 1'b0;
    chk("seq_drained", VW'(sbq.size()), '0);
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", {191'd0, busy}, '0);
  endtask

  initial begin
    vec_t          b;
    vec_t          s;
    logic [PW-1:0] n;
    int            c0;
    rst = 1'b0; start = 1'b0; stall = 1'b0; len_m1 = '0;
    base_in = '0; step_in = '0; N_in = '0;
    do_reset();

    // ch0 3*2^k mod 17, ch1 16^k mod 17, ch2 random
    b = mk3(64'd3, 64'd1, 64'($urandom_range(0, 16)));
    s = mk3(64'd2, 64'd16, 64'($urandom_range(1, 16)));
    start_seq(b, s, 64'd17, 3, 1'b1);
    wait_idle(1'b0);

    // stall held for 5 cycles while vector 2 is pending
    c0 = cyc;
    start_seq(b, s, 64'd17, 3, 1'b0);
    wait_cyc(c0 + 1 + 2 * (LAT + 1));
    stall = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    stall = 1'b0;
    wait_idle(1'b0);

    // start pulsed during WAIT must be ignored
    c0 = cyc;
    start_seq(b, s, 64'd17, 3, 1'b1);
    wait_cyc(c0 + 2);
    base_in = rand_vec(); N_in = 64'd5; len_m1 = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(1'b0);

    // single-vector job
    start_seq(b, s, 64'd17, 0, 1'b1);
    wait_idle(1'b0);

    // reset during WAIT, then restart from base
    c0 = cyc;
    start_seq(b, s, 64'd17, 3, 1'b1);
    wait_cyc(c0 + 3);
    do_reset();
    start_seq(b, s, 64'd17, 3, 1'b1);
    wait_idle(1'b0);

    // Goldilocks-style modulus: (N-1)^2 mod N = 1 needs the full 128-bit product
    n = 64'hFFFF_FFFF_0000_0001;
    b = mk3(n - 64'd1, n - 64'd1, n - 64'd1);
    s = mk3(n - 64'd1, n - 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    start_seq(b, s, n, 2, 1'b1);
    wait_idle(1'b0);

    for (int t = 0; t < 12; t++) begin
      if (t % 3 == 0) n = 64'($urandom_range(2, 1000));
      else            n = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      start_seq(rand_vec(), rand_vec(), n, $urandom_range(0, 5), 1'b0);
      wait_idle(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
